// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  function automatic logic [2:0] alu_op(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: alu_op = ALU_SUB;
      CMD_AND, CMD_TST: alu_op = ALU_AND;
      CMD_ORR:          alu_op = ALU_ORR;
      CMD_EOR:          alu_op = ALU_EOR;
      default:          alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle controller.
interface multicycle_controller_if #(parameter int ALU_CTL_W = 2);
  logic [3:0]           cond;
  logic [1:0]           op;
  logic [5:0]           funct;
  logic [3:0]           rd;
  logic [3:0]           alu_flags;
  logic                 mem_ready;
  logic                 pc_w, ir_w, reg_w, mem_w, adr_src, alu_src_a;
  logic [1:0]           alu_src_b, result_src, imm_src, reg_src;
  logic [ALU_CTL_W-1:0] alu_ctl;
  logic                 illegal;
  logic [3:0]           flags_q;

  modport master (
    output cond, op, funct, rd, alu_flags, mem_ready,
    input  pc_w, ir_w, reg_w, mem_w, adr_src, alu_src_a, alu_src_b, result_src,
           imm_src, reg_src, alu_ctl, illegal, flags_q
  );
  modport slave (
    input  cond, op, funct, rd, alu_flags, mem_ready,
    output pc_w, ir_w, reg_w, mem_w, adr_src, alu_src_a, alu_src_b, result_src,
           imm_src, reg_src, alu_ctl, illegal, flags_q
  );
endinterface

// File: rtl/cond_unit.sv
// Condition-code evaluator plus the architectural NZCV register.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       we_nz,
  input  logic       we_cv,
  output logic       cond_ex,
  output logic [3:0] flags_q
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // A failed condition suppresses the flag update as well as the writeback.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_q <= 4'b0000;
    end else begin
      if (we_nz && cond_ex) flags_q[3:2] <= alu_flags[3:2];
      if (we_cv && cond_ex) flags_q[1:0] <= alu_flags[1:0];
    end
  end
endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing fetch/decode/memory/ALU phases of the multicycle ARM datapath.
// Optional conditional execution and NZCV register under COND_EXEC_EN.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int ALU_CTL_W = 2
) (
  input logic                     clk,
  input logic                     reset_n,
  multicycle_controller_if.slave  bus
);
  state_t     state, state_nxt;
  logic [3:0] cmd;
  logic       cmd_ok, no_wb, s_bit, upd_cv, exec_st;
  logic       flags_we_nz, flags_we_cv, cond_ex;
  logic [3:0] flags_q;
  logic       pc_w_c, ir_w_c, reg_w_c, mem_w_c;
  logic [2:0] alu_ctl_full;
  logic       rd_pc;

  assign cmd   = bus.funct[4:1];
  assign no_wb = (cmd == CMD_CMP) || (cmd == CMD_TST);
  assign s_bit = bus.funct[0] || no_wb;
  assign upd_cv = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
  assign rd_pc = (bus.rd == 4'd15);

  always_comb begin
    cmd_ok = 1'b0;
    case (cmd)
      CMD_AND, CMD_SUB, CMD_ADD, CMD_TST, CMD_CMP, CMD_ORR: cmd_ok = 1'b1;
      CMD_EOR: cmd_ok = (ALU_CTL_W == 3);
      default: cmd_ok = 1'b0;
    endcase
  end

  assign exec_st     = (state == S_EXECR) || (state == S_EXECI);
  assign flags_we_nz = exec_st && s_bit;
  assign flags_we_cv = flags_we_nz && upd_cv;

`ifdef COND_EXEC_EN
  cond_unit u_cond (
    .clk       (clk),
    .reset_n   (reset_n),
    .cond      (bus.cond),
    .alu_flags (bus.alu_flags),
    .we_nz     (flags_we_nz),
    .we_cv     (flags_we_cv),
    .cond_ex   (cond_ex),
    .flags_q   (flags_q)
  );
`else
  logic unused_cond_path;
  assign unused_cond_path = ^{bus.cond, bus.alu_flags, flags_we_nz, flags_we_cv};
  assign cond_ex = 1'b1;
  assign flags_q = 4'b0000;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    pc_w_c         = 1'b0;
    ir_w_c         = 1'b0;
    reg_w_c        = 1'b0;
    mem_w_c        = 1'b0;
    bus.adr_src    = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'd0;
    bus.result_src = 2'd0;
    bus.illegal    = 1'b0;
    alu_ctl_full   = ALU_ADD;
    case (state)
      S_FETCH: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'd2;
        bus.result_src = 2'd2;
        ir_w_c         = bus.mem_ready;
        pc_w_c         = bus.mem_ready;
        if (bus.mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'd2;
        bus.result_src = 2'd2;
        case (bus.op)
          2'b01: state_nxt = S_MEMADR;
          2'b10: state_nxt = S_BRANCH;
          2'b00: begin
            if (cmd_ok) state_nxt = bus.funct[5] ? S_EXECI : S_EXECR;
            else begin
              bus.illegal = 1'b1;
              state_nxt   = S_FETCH;
            end
          end
          default: begin
            bus.illegal = 1'b1;
            state_nxt   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_b = 2'd1;
        state_nxt     = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        bus.adr_src = 1'b1;
        if (bus.mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWRITE: begin
        bus.adr_src = 1'b1;
        mem_w_c     = cond_ex;
        if (bus.mem_ready) state_nxt = S_FETCH;
      end
      S_MEMWB: begin
        bus.result_src = 2'd1;
        reg_w_c        = cond_ex;
        pc_w_c         = cond_ex && rd_pc;
        state_nxt      = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        bus.alu_src_b = (state == S_EXECI) ? 2'd1 : 2'd0;
        alu_ctl_full  = alu_op(cmd);
        state_nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w_c   = cond_ex && !no_wb;
        pc_w_c    = cond_ex && !no_wb && rd_pc;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_b  = 2'd1;
        bus.result_src = 2'd2;
        pc_w_c         = cond_ex;
        state_nxt      = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign bus.pc_w     = pc_w_c  && reset_n;
  assign bus.ir_w     = ir_w_c  && reset_n;
  assign bus.reg_w    = reg_w_c && reset_n;
  assign bus.mem_w    = mem_w_c && reset_n;
  assign bus.alu_ctl  = ALU_CTL_W'(alu_ctl_full);
  assign bus.imm_src  = bus.op;
  assign bus.reg_src  = {bus.op == 2'b01, bus.op == 2'b10};
  assign bus.flags_q  = flags_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller, two instances (ALU_CTL_W = 2 and 3) sharing inputs.
module tb_multicycle_controller;
  import ctrl_pkg::*;

`ifdef COND_EXEC_EN
  localparam bit CB = 1'b1;
`else
  localparam bit CB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad = 0;
  int   memw_cnt;

  multicycle_controller_if #(.ALU_CTL_W(2)) b2 ();
  multicycle_controller_if #(.ALU_CTL_W(3)) b3 ();

  assign b3.cond      = b2.cond;
  assign b3.op        = b2.op;
  assign b3.funct     = b2.funct;
  assign b3.rd        = b2.rd;
  assign b3.alu_flags = b2.alu_flags;
  assign b3.mem_ready = b2.mem_ready;

  multicycle_controller #(.ALU_CTL_W(2)) u2 (.clk(clk), .reset_n(reset_n), .bus(b2));
  multicycle_controller #(.ALU_CTL_W(3)) u3 (.clk(clk), .reset_n(reset_n), .bus(b3));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_dp(input string tag, input logic [5:0] funct, input logic [3:0] rd,
                        input logic [3:0] cond, input logic [3:0] fl, input logic [2:0] ctl,
                        input logic regw, input logic pcw, input logic [3:0] fexp);
    b2.op = 2'b00; b2.funct = funct; b2.rd = rd; b2.cond = cond;
    b2.alu_flags = fl; b2.mem_ready = 1'b1;
    #1;
    chk({tag, ".fetch_ir_w"}, 32'(b2.ir_w), 32'd1);
    tick();
    chk({tag, ".decode_illegal"}, 32'(b2.illegal), 32'd0);
    tick();
    chk({tag, ".exec_src_b"}, 32'(b2.alu_src_b), {31'd0, funct[5]});
    chk({tag, ".exec_alu_ctl"}, 32'(b2.alu_ctl), 32'(ctl));
    chk({tag, ".exec_reg_w"}, 32'(b2.reg_w), 32'd0);
    tick();
    chk({tag, ".aluwb_reg_w"}, 32'(b2.reg_w), 32'(regw));
    chk({tag, ".aluwb_pc_w"}, 32'(b2.pc_w), 32'(pcw));
    chk({tag, ".flags_q"}, 32'(b2.flags_q), 32'(fexp));
    tick();
    chk({tag, ".back_fetch"}, 32'(u2.state), 32'(S_FETCH));
  endtask

  initial begin
    reset_n = 1'b0;
    b2.op = 2'b01; b2.funct = 6'b011000; b2.rd = 4'd0; b2.cond = COND_AL;
    b2.alu_flags = 4'b0000; b2.mem_ready = 1'b1;
    #1;
    chk("rst.pc_w", 32'(b2.pc_w), 32'd0);
    chk("rst.ir_w", 32'(b2.ir_w), 32'd0);
    tick(); tick();
    chk("rst.state", 32'(u2.state), 32'(S_FETCH));
    chk("rst.flags", 32'(b2.flags_q), 32'd0);
    reset_n = 1'b1;

    // LDR with one stalled MEMREAD cycle
    b2.funct = 6'b011001; b2.rd = 4'd4;
    #1;
    chk("ldr.fetch_ir_w", 32'(b2.ir_w), 32'd1);
    chk("ldr.fetch_pc_w", 32'(b2.pc_w), 32'd1);
    chk("ldr.fetch_src_a", 32'(b2.alu_src_a), 32'd1);
    chk("ldr.fetch_src_b", 32'(b2.alu_src_b), 32'd2);
    chk("ldr.fetch_res", 32'(b2.result_src), 32'd2);
    chk("ldr.imm_src", 32'(b2.imm_src), 32'd1);
    chk("ldr.reg_src", 32'(b2.reg_src), 32'd2);
    tick();
    chk("ldr.decode_src_b", 32'(b2.alu_src_b), 32'd2);
    chk("ldr.decode_ir_w", 32'(b2.ir_w), 32'd0);
    chk("ldr.decode_reg_w", 32'(b2.reg_w), 32'd0);
    tick();
    chk("ldr.memadr_src_b", 32'(b2.alu_src_b), 32'd1);
    chk("ldr.memadr_reg_w", 32'(b2.reg_w), 32'd0);
    tick();
    b2.mem_ready = 1'b0;
    #1;
    chk("ldr.memread_adr", 32'(b2.adr_src), 32'd1);
    chk("ldr.memread_reg_w", 32'(b2.reg_w), 32'd0);
    tick();
    chk("ldr.memread_hold", 32'(u2.state), 32'(S_MEMREAD));
    b2.mem_ready = 1'b1;
    tick();
    chk("ldr.memwb_reg_w", 32'(b2.reg_w), 32'd1);
    chk("ldr.memwb_res", 32'(b2.result_src), 32'd1);
    chk("ldr.memwb_pc_w", 32'(b2.pc_w), 32'd0);
    tick();
    chk("ldr.back_fetch", 32'(u2.state), 32'(S_FETCH));

    // Stalled fetch, then STR with three wait cycles in MEMWRITE
    b2.mem_ready = 1'b0; b2.funct = 6'b011000;
    #1;
    chk("fstall.ir_w", 32'(b2.ir_w), 32'd0);
    chk("fstall.pc_w", 32'(b2.pc_w), 32'd0);
    tick();
    chk("fstall.hold", 32'(u2.state), 32'(S_FETCH));
    b2.mem_ready = 1'b1;
    tick(); tick(); tick();
    chk("str.memwrite", 32'(u2.state), 32'(S_MEMWRITE));
    memw_cnt = 0;
    b2.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) b2.mem_ready = 1'b1;
      #1;
      if (b2.mem_w === 1'b1) memw_cnt++;
      tick();
    end
    chk("str.mem_w_cycles", 32'(memw_cnt), 32'd4);
    chk("str.back_fetch", 32'(u2.state), 32'(S_FETCH));
    chk("str.fetch_mem_w", 32'(b2.mem_w), 32'd0);

    // Reset abandoning a stalled store
    tick(); tick(); tick();
    b2.mem_ready = 1'b0;
    #1;
    chk("rst2.pre_mem_w", 32'(b2.mem_w), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst2.mem_w_forced", 32'(b2.mem_w), 32'd0);
    tick();
    chk("rst2.mem_w_low", 32'(b2.mem_w), 32'd0);
    tick();
    chk("rst2.state", 32'(u2.state), 32'(S_FETCH));
    chk("rst2.flags", 32'(b2.flags_q), 32'd0);
    reset_n = 1'b1;
    b2.mem_ready = 1'b1;

    // Data processing: tag funct rd cond alu_flags alu_ctl reg_w pc_w flags_q
    run_dp("cmp",    6'b010101, 4'd15, COND_AL, 4'b0100, 3'd1, 1'b0, 1'b0, CB ? 4'b0100 : 4'b0000);
    run_dp("add_ne", 6'b001000, 4'd3,  COND_NE, 4'b1111, 3'd0, !CB,  1'b0, CB ? 4'b0100 : 4'b0000);
    run_dp("add_eq", 6'b001000, 4'd3,  COND_EQ, 4'b1111, 3'd0, 1'b1, 1'b0, CB ? 4'b0100 : 4'b0000);
    run_dp("add_pc", 6'b101000, 4'd15, COND_AL, 4'b1011, 3'd0, 1'b1, 1'b1, CB ? 4'b0100 : 4'b0000);
    run_dp("orr_s",  6'b011001, 4'd2,  COND_AL, 4'b1111, 3'd3, 1'b1, 1'b0, CB ? 4'b1100 : 4'b0000);
    run_dp("sub_s",  6'b000101, 4'd2,  COND_AL, 4'b0011, 3'd1, 1'b1, 1'b0, CB ? 4'b0011 : 4'b0000);
    run_dp("and",    6'b000000, 4'd2,  COND_AL, 4'b1111, 3'd2, 1'b1, 1'b0, CB ? 4'b0011 : 4'b0000);
    run_dp("tst",    6'b010001, 4'd2,  COND_AL, 4'b1000, 3'd2, 1'b0, 1'b0, CB ? 4'b1011 : 4'b0000);

    // Branch
    b2.op = 2'b10; b2.funct = 6'b100000; b2.rd = 4'd0;
    #1;
    tick(); tick();
    chk("b.pc_w", 32'(b2.pc_w), 32'd1);
    chk("b.src_b", 32'(b2.alu_src_b), 32'd1);
    chk("b.res", 32'(b2.result_src), 32'd2);
    chk("b.imm_src", 32'(b2.imm_src), 32'd2);
    chk("b.reg_src", 32'(b2.reg_src), 32'd1);
    tick();
    chk("b.back_fetch", 32'(u2.state), 32'(S_FETCH));

    // Undefined op and unsupported cmd
    b2.op = 2'b11;
    #1;
    tick();
    chk("op11.illegal", 32'(b2.illegal), 32'd1);
    tick();
    chk("op11.fetch", 32'(u2.state), 32'(S_FETCH));
    chk("op11.pulse_end", 32'(b2.illegal), 32'd0);
    b2.op = 2'b00; b2.funct = 6'b001110;
    #1;
    tick();
    chk("rsc.illegal", 32'(b2.illegal), 32'd1);
    tick();
    chk("rsc.fetch", 32'(u2.state), 32'(S_FETCH));

    // EOR: unsupported with 2-bit alu_ctl, decoded with 3-bit
    b2.funct = 6'b000010;
    #1;
    tick();
    chk("eor2.illegal", 32'(b2.illegal), 32'd1);
    chk("eor3.illegal", 32'(b3.illegal), 32'd0);
    tick();
    chk("eor2.fetch", 32'(u2.state), 32'(S_FETCH));
    chk("eor3.alu_ctl", 32'(b3.alu_ctl), 32'd4);
    chk("eor3.src_b", 32'(b3.alu_src_b), 32'd0);
    tick();
    chk("eor3.reg_w", 32'(b3.reg_w), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control unit for the ARM CPU core: a Moore FSM that sequences fetch, decode, memory and ALU phases over several cycles and drives the shared-memory datapath. It generalises the single-cycle main/ALU decoding with:
- a parametrised ALU control width;
- a memory ready handshake;
- CMP/TST handling (set flags, no register write);
- optional conditional execution.

It sits between the instruction register and the multicycle datapath.

## Interface
Parameters:
- ALU_CTL_W, 2, width of alu_ctl; legal values 2 or 3. Value 3 enables EOR decode.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous, active-low reset
- cond  input  4  instr[31:28]
- op  input  2  instr[27:26]
- funct  input  6  instr[25:20]
- rd  input  4  instr[15:12]
- alu_flags  input  4  NZCV from the ALU, current cycle
- mem_ready  input  1  memory completes the current access this cycle
- pc_w, ir_w, reg_w, mem_w, adr_src  output  1  datapath enables and selects
- alu_src_a  output  1  0 = register A, 1 = PC
- alu_src_b  output  2  0 = register B, 1 = extended immediate, 2 = constant 4
- result_src  output  2  0 = ALU out register, 1 = memory data, 2 = ALU direct
- imm_src, reg_src  output  2  same encodings as the single-cycle decoder
- alu_ctl  output  ALU_CTL_W  operation: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR
- illegal  output  1  one-cycle pulse in DECODE for an unsupported encoding
- flags_q  output  4  architectural NZCV register

## Operation
States are FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.

Transitions:
- FETCH → DECODE only when mem_ready = 1; otherwise hold.
- DECODE:
  - op = 01 → MEMADR.
  - op = 00 with funct[5] = 0 → EXECR.
  - op = 00 with funct[5] = 1 → EXECI.
  - op = 10 → BRANCH.
  - op = 11, or an unsupported cmd → FETCH, with illegal = 1.
- MEMADR → MEMREAD if funct[0] = 1, else MEMWRITE.
- MEMREAD → MEMWB, and MEMWRITE → FETCH, only on mem_ready; hold otherwise.
- MEMWB, ALUWB and BRANCH → FETCH.
- EXECR and EXECI → ALUWB.

Per-state outputs (all unlisted outputs are 0):
- FETCH: alu_src_a = 1, alu_src_b = 2, result_src = 2, ADD. ir_w = pc_w = mem_ready.
- DECODE: alu_src_a = 1, alu_src_b = 2, result_src = 2 (forms PC+8).
- MEMADR: alu_src_b = 1, ADD.
- MEMREAD: adr_src = 1.
- MEMWRITE: adr_src = 1, mem_w = 1. mem_w is held every cycle of the state until mem_ready.
- MEMWB: result_src = 1, reg_w = 1.
- EXECR / EXECI: alu_src_b = 0 / 1, alu_ctl decoded from cmd.
- ALUWB: reg_w = 1 unless cmd is CMP or TST.
- BRANCH: alu_src_b = 1, result_src = 2, ADD, pc_w = 1.
- MEMWB or ALUWB with rd = 15 and reg_w = 1: pc_w = 1.
- imm_src = op; reg_src = {op == 01, op == 10} in all states.

ALU decode of cmd = funct[4:1] (ADD, SUB, AND, ORR, CMP, TST are supported in both configurations; EOR only when ALU_CTL_W = 3):
- 0100 ADD: alu_ctl 0, flag update NZCV.
- 0010 SUB: alu_ctl 1, flag update NZCV.
- 0000 AND: alu_ctl 2, flag update NZ.
- 1100 ORR: alu_ctl 3, flag update NZ.
- 0001 EOR: alu_ctl 4, flag update NZ. With ALU_CTL_W = 2, EOR is unsupported.
- 1010 CMP: SUB, flags are always written.
- 1000 TST: AND, flags are always written.
- All other data-processing instructions write flags only when funct[0] = 1.

Flags and reset:
- Flags are written at the clock edge leaving EXECR/EXECI, from alu_flags.
- While reset_n = 0, all write enables (pc_w, ir_w, reg_w, mem_w) are forced to 0.
- At the first clock edge with reset_n = 0: state ← FETCH and flags_q ← 0000. A reset mid-access abandons that access.

## Timing
- Moore FSM. Only ir_w and pc_w in FETCH combine state with mem_ready.
- Cycles per instruction with mem_ready tied high:
  - LDR 5
  - STR 4
  - data-processing 4
  - B 3
  - illegal 2
- Each mem_ready-low cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- illegal is asserted only in the DECODE cycle.

## Configuration
- COND_EXEC_EN defined:
  - cond_ex is evaluated from cond and flags_q: EQ … LE, AL = 1110 true, 1111 false.
  - reg_w, mem_w, the non-FETCH pc_w and the flags write are each ANDed with cond_ex.
  - The state sequence is unchanged.
- COND_EXEC_EN undefined:
  - cond_ex = 1; cond is ignored.
  - flags_q is tied to 0000 and alu_flags is ignored.

## Structure
- ctrl_pkg holds:
  - state enum;
  - ALU_ADD/SUB/AND/ORR/EOR constants;
  - cmd codes;
  - condition code constants.
- Sub-module cond_unit contains the condition evaluator and the flags register. It is instantiated only under COND_EXEC_EN.

## Test plan
- Reset: hold reset_n low 2 cycles mid-MEMWRITE → FETCH, mem_w = 0 during reset, flags_q = 0000.
- LDR (op = 01, funct = 011001), mem_ready high → FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_w asserted only in MEMWB.
- STR with mem_ready low for 3 cycles in MEMWRITE → mem_w high for 4 cycles, then FETCH.
- CMP (cmd 1010), alu_flags = 0100 → flags_q = 0100; reg_w = 0 in ALUWB.
- COND_EXEC_EN, flags Z = 1, ADD with cond NE → reg_w = 0 in ALUWB. Same instruction with cond EQ → reg_w = 1.
- ALU_CTL_W = 2, EOR → illegal pulse in DECODE, next state FETCH. ALU_CTL_W = 3, EOR → alu_ctl = 4 in EXECR.
